fp_swap_align_stage: RTL and testbench
======================================

// Module: fp_swap_align_stage
// PURPOSE
//  Add/sub operand swap-and-align-prep stage for FP32 / FP16x2. Instantiates abs_comparator on the
//  incoming operands, orders each lane into big/small magnitude, and registers the swapped operands,
//  the clamped exponent-difference shift amounts and the effective-subtract flags.
//  Sits between operand issue and the mantissa alignment shifter. Valid/ready on both sides.
// PARAMETERS
//  SHAMT32_MAX  26  FP32 shift saturation (24-bit significand + guard + round)
//  SHAMT16_MAX  13  FP16 per-lane shift saturation (11-bit significand + guard + round)
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset, asynchronous, active-high
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        stage accepts beat
//  in_fmt     in   fp_fmt_e FP16 = packed FP16x2; any other value = FP32
//  in_sub     in   1        operation is subtract (Y negated)
//  in_x       in   fp_vec_u operand X
//  in_y       in   fp_vec_u operand Y
//  out_valid  out  1        result beat valid
//  out_ready  in   1        downstream accepts beat
//  out_fmt    out  fp_fmt_e registered format
//  out_big    out  fp_vec_u per lane, larger-magnitude operand (Y sign flipped when in_sub=1)
//  out_small  out  fp_vec_u per lane, smaller-magnitude operand (same sign rule)
//  out_shamt_h out 5        FP32: big-small exponent diff; FP16: hi-lane diff (bits [4] = 0)
//  out_shamt_l out 4        FP16 lo-lane diff; 0 in FP32
//  out_effsub_h out 1       hi lane / FP32: sign(X) ^ sign(Y) ^ in_sub
//  out_effsub_l out 1       lo lane: same, FP16 only; 0 in FP32
//  out_swap_h  out 1        registered swap_h from comparator
//  out_swap_l  out 1        registered swap_l; 0 in FP32
// BEHAVIOUR
//  - Reset: out_valid=0, all data outputs 0, out_fmt=FP32; in_ready=1 one cycle after rst deasserts.
//  - Transfer on in_valid&in_ready; result appears on out_valid the next cycle (latency 1).
//  - Output held stable while out_valid&~out_ready; data changes only on a transfer.
//  - swap=1 -> big=Y', small=X; swap=0 (incl. |X|==|Y|) -> big=X, small=Y'. Y' = Y with sign^in_sub.
//  - Exponent fields: FP32 [30:23]; FP16 hi [30:26], lo [14:10]. Effective exp = field, or 1 if field==0.
//  - shamt = eff_exp(big) - eff_exp(small), always >=0; saturate at SHAMT32_MAX / SHAMT16_MAX.
//  - FP32 ignores swap_l; lo-lane outputs forced 0. Inf/NaN not special-cased here (exp 255/31 used as-is).
//  - Mid-operation reset clears the held beat; no partial beat survives.
// CONFIGURATION
//  FPALL_ALIGN_SKID_EN defined: 2-entry (main + skid) buffer; in_ready registered = ~skid_full;
//   a beat arriving while out stalled goes to skid; skid drains into main on next out handshake.
//   Full throughput with no combinational out_ready->in_ready path.
//  Undefined: single register; in_ready = ~out_valid | out_ready (combinational).
//  Both: identical beat order and data; no beat dropped or duplicated.
// TESTING
//  - FP32 X=0x3F800000, Y=0x40400000, sub=0 -> big=0x40400000, small=0x3F800000, shamt_h=1, swap_h=1, effsub_h=0.
//  - FP16x2 X={hi 0x3C00, lo 0x4200}, Y={0x4000,0x3C00}, sub=1 -> hi: big=0xC000, shamt_h=1, swap_h=1;
//    lo: big=0x4200, small=0xBC00, shamt_l=1, swap_l=0; effsub_h=effsub_l=1.
//  - FP32 X=0x7F000000, Y=0x00000001 -> shamt_h=26 (saturated), swap_h=0; FP16 lo 0x0400 vs 0x0001 -> shamt_l=0.
//  - Equal magnitude X=0x40000000, Y=0xC0000000 -> swap_h=0, big=X, effsub_h=1, shamt_h=0.
//  - Stream 8 beats, out_ready low for cycles 3-5 -> outputs stable while stalled, all 8 beats in order;
//    with FPALL_ALIGN_SKID_EN in_ready never depends on same-cycle out_ready.
//  - Assert rst while out_valid=1 and stalled -> out_valid=0 immediately, outputs 0; next beat accepted normally.

Source files
------------

// File: rtl/fp_swap_align_stage.sv
// FP32 / FP16x2 add-sub swap-and-align-prep stage: orders each lane by magnitude and registers
// the swapped operands, clamped shift amounts and effective-subtract flags. Optional FPALL_ALIGN_SKID_EN.

package fp_swap_align_pkg;
    typedef enum logic [1:0] {
        FMT_FP32 = 2'd0,
        FMT_FP16 = 2'd1,
        FMT_BF16 = 2'd2,
        FMT_RSVD = 2'd3
    } fp_fmt_e;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } fp16x2_t;

    typedef union packed {
        logic [31:0] w;
        fp16x2_t     h;
    } fp_vec_u;
endpackage

// Magnitude compare of X and Y ignoring signs; swap means |Y| > |X| (ties keep X as big).
module abs_comparator
    import fp_swap_align_pkg::*;
(
    input  fp_fmt_e     fmt,
    input  logic [30:0] x_mag,
    input  logic [30:0] y_mag,
    output logic        swap_h,
    output logic        swap_l
);
    always_comb begin
        swap_h = 1'b0;
        swap_l = 1'b0;
        if (fmt == FMT_FP16) begin
            swap_h = y_mag[30:16] > x_mag[30:16];
            swap_l = y_mag[14:0] > x_mag[14:0];
        end else begin
            swap_h = y_mag > x_mag;
        end
    end
endmodule

module fp_swap_align_stage
    import fp_swap_align_pkg::*;
#(
    parameter int SHAMT32_MAX = 26,
    parameter int SHAMT16_MAX = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  fp_fmt_e     in_fmt,
    input  logic        in_sub,
    input  fp_vec_u     in_x,
    input  fp_vec_u     in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output fp_fmt_e     out_fmt,
    output fp_vec_u     out_big,
    output fp_vec_u     out_small,
    output logic [4:0]  out_shamt_h,
    output logic [3:0]  out_shamt_l,
    output logic        out_effsub_h,
    output logic        out_effsub_l,
    output logic        out_swap_h,
    output logic        out_swap_l
);
    // Handshake: a beat moves on a cycle where valid and ready are both high; the sender
    // holds valid and data until that happens, and the stage holds its output likewise.

    typedef struct packed {
        fp_fmt_e    fmt;
        fp_vec_u    big;
        fp_vec_u    sml;
        logic [4:0] shamt_h;
        logic [3:0] shamt_l;
        logic       effsub_h;
        logic       effsub_l;
        logic       swap_h;
        logic       swap_l;
    } beat_t;

    function automatic logic [7:0] eff_exp8(input logic [7:0] e);
        return (e == 8'd0) ? 8'd1 : e;
    endfunction

    function automatic logic [4:0] eff_exp5(input logic [4:0] e);
        return (e == 5'd0) ? 5'd1 : e;
    endfunction

    logic       cmp_swap_h;
    logic       cmp_swap_l;
    logic       is16;
    logic       lo_swap;
    fp_vec_u    y_neg;
    logic [7:0] diff32;
    logic [4:0] diff_hi;
    logic [4:0] diff_lo;
    beat_t      new_beat;

    abs_comparator u_cmp (
        .fmt    (in_fmt),
        .x_mag  (in_x.w[30:0]),
        .y_mag  (in_y.w[30:0]),
        .swap_h (cmp_swap_h),
        .swap_l (cmp_swap_l)
    );

    always_comb begin
        is16  = (in_fmt == FMT_FP16);
        y_neg = in_y;
        y_neg.w[31] = in_y.w[31] ^ in_sub;
        if (is16) begin
            y_neg.w[15] = in_y.w[15] ^ in_sub;
        end
        // In FP32 the low half belongs to the same operand as the high half.
        lo_swap = is16 ? cmp_swap_l : cmp_swap_h;

        new_beat        = '0;
        new_beat.fmt    = in_fmt;
        new_beat.big.h.hi = cmp_swap_h ? y_neg.h.hi : in_x.h.hi;
        new_beat.sml.h.hi = cmp_swap_h ? in_x.h.hi  : y_neg.h.hi;
        new_beat.big.h.lo = lo_swap    ? y_neg.h.lo : in_x.h.lo;
        new_beat.sml.h.lo = lo_swap    ? in_x.h.lo  : y_neg.h.lo;

        diff32  = eff_exp8(new_beat.big.w[30:23]) - eff_exp8(new_beat.sml.w[30:23]);
        diff_hi = eff_exp5(new_beat.big.w[30:26]) - eff_exp5(new_beat.sml.w[30:26]);
        diff_lo = eff_exp5(new_beat.big.w[14:10]) - eff_exp5(new_beat.sml.w[14:10]);

        new_beat.effsub_h = in_x.w[31] ^ in_y.w[31] ^ in_sub;
        new_beat.swap_h   = cmp_swap_h;
        if (is16) begin
            new_beat.shamt_h  = (diff_hi > 5'(SHAMT16_MAX)) ? 5'(SHAMT16_MAX) : diff_hi;
            new_beat.shamt_l  = (diff_lo > 5'(SHAMT16_MAX)) ? 4'(SHAMT16_MAX) : diff_lo[3:0];
            new_beat.effsub_l = in_x.w[15] ^ in_y.w[15] ^ in_sub;
            new_beat.swap_l   = cmp_swap_l;
        end else begin
            new_beat.shamt_h  = (diff32 > 8'(SHAMT32_MAX)) ? 5'(SHAMT32_MAX) : diff32[4:0];
        end
    end

    beat_t main_q;
    beat_t main_d;
    logic  main_vld_q;
    logic  main_vld_d;

`ifdef FPALL_ALIGN_SKID_EN
    beat_t skid_q;
    beat_t skid_d;
    logic  skid_vld_q;
    logic  skid_vld_d;
    logic  in_ready_q;
    logic  in_ready_d;
    logic  pop;
    logic  push;

    assign in_ready = in_ready_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        pop        = main_vld_q & out_ready;
        push       = in_valid & in_ready_q;
        if (skid_vld_q) begin
            // in_ready is low while the skid is full, so only a drain can happen here.
            if (pop) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end
        end else if (pop || !main_vld_q) begin
            main_vld_d = push;
            if (push) begin
                main_d = new_beat;
            end
        end else if (push) begin
            skid_d     = new_beat;
            skid_vld_d = 1'b1;
        end
        in_ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    logic init_q;
    logic init_d;

    // init_q keeps in_ready low until the first clock after reset release.
    assign in_ready = init_q & (~main_vld_q | out_ready);

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        init_d     = 1'b1;
        if (in_valid && in_ready) begin
            main_d     = new_beat;
            main_vld_d = 1'b1;
        end else if (out_ready) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            init_q     <= init_d;
        end
    end
`endif

    assign out_valid    = main_vld_q;
    assign out_fmt      = main_q.fmt;
    assign out_big      = main_q.big;
    assign out_small    = main_q.sml;
    assign out_shamt_h  = main_q.shamt_h;
    assign out_shamt_l  = main_q.shamt_l;
    assign out_effsub_h = main_q.effsub_h;
    assign out_effsub_l = main_q.effsub_l;
    assign out_swap_h   = main_q.swap_h;
    assign out_swap_l   = main_q.swap_l;
endmodule

// File: tb/tb_fp_swap_align_stage.sv
// Self-checking bench for fp_swap_align_stage: directed spec cases, stall/stream order, random
// traffic against an arithmetic reference model, and mid-stall reset.
module tb_fp_swap_align_stage;
  import fp_swap_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fp_fmt_e     in_fmt;
  logic        in_sub;
  fp_vec_u     in_x;
  fp_vec_u     in_y;
  logic        out_valid;
  logic        out_ready;
  fp_fmt_e     out_fmt;
  fp_vec_u     out_big;
  fp_vec_u     out_small;
  logic [4:0]  out_shamt_h;
  logic [3:0]  out_shamt_l;
  logic        out_effsub_h;
  logic        out_effsub_l;
  logic        out_swap_h;
  logic        out_swap_l;

  int n_checks = 0;
  int n_pass = 0;
  logic [78:0] exp_q[$];

  fp_swap_align_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_sub(in_sub), .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_fmt(out_fmt), .out_big(out_big), .out_small(out_small), .out_shamt_h(out_shamt_h),
    .out_shamt_l(out_shamt_l), .out_effsub_h(out_effsub_h), .out_effsub_l(out_effsub_l),
    .out_swap_h(out_swap_h), .out_swap_l(out_swap_l)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int eff(input int e);
    return (e == 0) ? 1 : e;
  endfunction

  function automatic void lane16(input logic [15:0] xl, input logic [15:0] yl, input logic sub,
                                 output logic [15:0] bl, output logic [15:0] sl, output int sh,
                                 output logic sw, output logic es);
    logic [15:0] yn;
    int mx;
    int my;
    yn = yl ^ {sub, 15'b0};
    mx = int'(xl) % 32768;
    my = int'(yl) % 32768;
    sw = (my > mx);
    bl = sw ? yn : xl;
    sl = sw ? xl : yn;
    sh = eff((int'(bl) / 1024) % 32) - eff((int'(sl) / 1024) % 32);
    if (sh > 13) sh = 13;
    es = xl[15] ^ yl[15] ^ sub;
  endfunction

  function automatic logic [78:0] model(input logic [1:0] fmt, input logic sub,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] b;
    logic [31:0] s;
    logic [15:0] bh, bl, sh16, sl16;
    int sh_h;
    int sh_l;
    logic eh, el, swh, swl;
    longint mx, my;
    sh_l = 0; el = 1'b0; swl = 1'b0;
    if (fmt == 2'd1) begin
      lane16(x[31:16], y[31:16], sub, bh, sh16, sh_h, swh, eh);
      lane16(x[15:0], y[15:0], sub, bl, sl16, sh_l, swl, el);
      b = {bh, bl};
      s = {sh16, sl16};
    end else begin
      mx = longint'(x) % 64'h8000_0000;
      my = longint'(y) % 64'h8000_0000;
      swh = (my > mx);
      b = swh ? (y ^ {sub, 31'b0}) : x;
      s = swh ? x : (y ^ {sub, 31'b0});
      sh_h = eff(int'(b >> 23) % 256) - eff(int'(s >> 23) % 256);
      if (sh_h > 26) sh_h = 26;
      eh = x[31] ^ y[31] ^ sub;
    end
    return {fmt, b, s, 5'(sh_h), 4'(sh_l), eh, el, swh, swl};
  endfunction

  function automatic logic [78:0] dut_beat();
    return {out_fmt, out_big, out_small, out_shamt_h, out_shamt_l,
            out_effsub_h, out_effsub_l, out_swap_h, out_swap_l};
  endfunction

  function automatic logic [1:0] rand_fmt();
    int r;
    r = $urandom_range(0, 7);
    if (r < 3) return 2'd1;
    if (r < 6) return 2'd0;
    return 2'(r - 4);
  endfunction

  function automatic void rand_ops(output logic [31:0] x, output logic [31:0] y);
    x = $urandom;
    case ($urandom_range(0, 3))
      0: y = $urandom;
      1: y = x ^ ($urandom & 32'h01FF_07FF);
      2: y = x ^ 32'h8000_8000;
      default: y = $urandom & 32'h807F_83FF;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [1:0] f, input logic sub,
                      input logic [31:0] x, input logic [31:0] y, input logic ordy);
    @(negedge clk);
    in_valid = v;
    in_fmt = fp_fmt_e'(f);
    in_sub = sub;
    in_x.w = x;
    in_y.w = y;
    out_ready = ordy;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (dut_beat() !== 79'h0) $display("FAIL reset_data: got %h expected 0", dut_beat());
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL release_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_release: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [1:0]  f[5]   = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    logic        s[5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] x[5]   = '{32'h3F800000, 32'h3C004200, 32'h7F000000, 32'h78000400, 32'h40000000};
    logic [31:0] y[5]   = '{32'h40400000, 32'h40003C00, 32'h00000001, 32'h00010001, 32'hC0000000};
    logic [78:0] e[5]   = '{
      {2'd0, 32'h40400000, 32'h3F800000, 5'd1,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0},
      {2'd1, 32'hC0004200, 32'h3C00BC00, 5'd1,  4'd1, 1'b1, 1'b1, 1'b1, 1'b0},
      {2'd0, 32'h7F000000, 32'h00000001, 5'd26, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
      {2'd1, 32'h78000400, 32'h00010001, 5'd13, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
      {2'd0, 32'h40000000, 32'hC0000000, 5'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, f[i], s[i], x[i], y[i], 1'b1);
      step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL directed%0d_latency: got out_valid %b expected 1", i, out_valid);
      else n_pass++;
      n_checks++;
      if (dut_beat() !== e[i]) $display("FAIL directed%0d_data: got %h expected %h", i, dut_beat(), e[i]);
      else n_pass++;
    end
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  f[8];
    logic        s[8];
    logic [31:0] x[8];
    logic [31:0] y[8];
    logic [78:0] snap;
    logic [78:0] ex;
    logic        prev_stall;
    logic        r0;
    int sent;
    int got;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      f[i] = rand_fmt();
      s[i] = 1'($urandom_range(0, 1));
      rand_ops(x[i], y[i]);
    end
    sent = 0; got = 0; prev_stall = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      if (sent < 8) step(1'b1, f[sent], s[sent], x[sent], y[sent], !(cyc >= 3 && cyc <= 5));
      else step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, !(cyc >= 3 && cyc <= 5));
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || dut_beat() !== snap)
          $display("FAIL stall_stable: got %b/%h expected 1/%h", out_valid, dut_beat(), snap);
        else n_pass++;
      end
`ifdef FPALL_ALIGN_SKID_EN
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      n_checks++;
      if (in_ready !== r0) $display("FAIL ready_comb_path: got %b expected %b", in_ready, r0);
      else n_pass++;
      out_ready = ~out_ready;
      #1;
`else
      r0 = 1'b0;
`endif
      if (in_valid && in_ready) begin
        exp_q.push_back(model(f[sent], s[sent], x[sent], y[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (dut_beat() !== ex) $display("FAIL stream_beat%0d: got %h expected %h", got, dut_beat(), ex);
        else n_pass++;
        got++;
      end
      prev_stall = out_valid && !out_ready;
      snap = dut_beat();
    end
    n_checks++;
    if (got !== 8) $display("FAIL stream_count: got %0d expected 8", got);
    else n_pass++;
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0]  f;
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic        v;
    logic [78:0] ex;
    int sent;
    int got;
    int bad;
    exp_q.delete();
    sent = 0; got = 0; bad = 0; v = 1'b0;
    f = 2'd0; s = 1'b0; x = '0; y = '0;
    for (int cyc = 0; cyc < 5000 && got < 300; cyc++) begin
      if (!v && sent < 300 && $urandom_range(0, 9) < 7) begin
        v = 1'b1;
        f = rand_fmt();
        s = 1'($urandom_range(0, 1));
        rand_ops(x, y);
      end
      step(v, f, s, x, y, ($urandom_range(0, 9) < 7));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(f, s, x, y));
        sent++;
        v = 1'b0;
      end
      if (out_valid && out_ready) begin
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (dut_beat() !== ex) begin
          if (bad < 10) $display("FAIL random_beat%0d: got %h expected %h", got, dut_beat(), ex);
          bad++;
        end else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got !== 300) $display("FAIL random_count: got %0d expected 300", got);
    else n_pass++;
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_mid_reset();
    step(1'b1, 2'd0, 1'b0, 32'h3F800000, 32'h40400000, 1'b0);
    step(1'b1, 2'd1, 1'b1, 32'h3C004200, 32'h40003C00, 1'b0);
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL midrst_stalled: got %b expected 1", out_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (dut_beat() !== 79'h0) $display("FAIL midrst_data: got %h expected 0", dut_beat());
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 2'd0, 1'b1, 32'h40000000, 32'h3F000000, 1'b1);
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || dut_beat() !== model(2'd0, 1'b1, 32'h40000000, 32'h3F000000))
      $display("FAIL midrst_next_beat: got %b/%h expected 1/%h", out_valid, dut_beat(),
               model(2'd0, 1'b1, 32'h40000000, 32'h3F000000));
    else n_pass++;
    step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_no_leftover: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_fmt = FMT_FP32;
    in_sub = 1'b0;
    in_x.w = '0;
    in_y.w = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
